// File: rtl/layer_mem_reader.sv
// Burst reader: streams length words from base_addr out of a 1-cycle memory.
// Optional running byte checksum when RD_CHECKSUM_EN is defined.
module layer_mem_reader #(
  parameter int ADDR_SIZE = 19,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE-1:0] length,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
`ifdef RD_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] issued_q;
  logic [ADDR_SIZE-1:0] len_q;
  logic [ADDR_SIZE-1:0] rem_q;
  logic                 inflight_q;
  logic [DATA_W-1:0]    fifo_q [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count_q;

  logic                 pop;
  logic                 pop_fifo;
  logic                 push;
  logic [1:0]           occ;
  logic                 accept;

  // Head of the stream bypasses the FIFO when only the returning word exists.
  always_comb begin
    out_data = '0;
    if (count_q != 2'd0)
      out_data = fifo_q[rd_ptr];
    else if (inflight_q)
      out_data = mem_data;
  end

  assign out_valid = (count_q != 2'd0) | inflight_q;
  assign pop       = out_valid & out_ready;
  assign pop_fifo  = pop & (count_q != 2'd0);
  assign push      = inflight_q & ~(pop & (count_q == 2'd0));
  assign occ       = count_q + {1'b0, inflight_q};
  assign accept    = (state == IDLE) & start;

  assign mem_rd    = (state == FETCH)
                   & (issued_q != len_q)
                   & ((occ - {1'b0, pop}) < 2'd2);
  assign mem_addr  = addr_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Burst control: state, address, issue and beat counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      issued_q <= '0;
      len_q    <= '0;
      rem_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            issued_q <= '0;
            len_q    <= length;
            rem_q    <= length;
            state    <= (length == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (mem_rd) begin
            addr_q   <= addr_q + 1'b1;
            issued_q <= issued_q + 1'b1;
          end
          if (pop) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == ADDR_SIZE'(1))
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: one read in flight plus a 2-entry skid FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= mem_rd;
      if (push) begin
        fifo_q[wr_ptr] <= mem_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop_fifo)
        rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

`ifdef RD_CHECKSUM_EN
  // Running sum of transferred beats, restarted on each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      checksum <= '0;
    else if (accept)
      checksum <= '0;
    else if (pop)
      checksum <= checksum + 16'(out_data);
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_layer_mem_reader.sv
// Directed bench for layer_mem_reader with a 1-cycle memory model.
// Define RD_CHECKSUM_EN to also check the checksum port.
module tb_layer_mem_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [18:0] base_addr = '0;
  logic [18:0] length = '0;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef RD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int total = 0;
  int bad = 0;

  layer_mem_reader #(.ADDR_SIZE(19), .DATA_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
`ifdef RD_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // memory[i] = i (low byte), one cycle read latency
  always @(posedge clk)
    if (mem_rd) mem_data <= mem_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready=1; 1: ready 1,0,0,1; 2: ready=1, start re-pulsed at c=3
  task automatic run_burst(input logic [18:0] base, input logic [18:0] len,
                           input int mode);
    logic [18:0] issued;
    int          beats;
    logic [15:0] sum;
    logic        stall;
    logic [7:0]  pdata;
    logic [18:0] ea;
    logic [7:0]  ed;
    bit          fin;
    issued = '0;
    beats = 0;
    sum = '0;
    stall = 1'b0;
    pdata = '0;
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    length = len;
    out_ready = 1'b1;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 2 && c == 3) begin
        start = 1'b1;
        base_addr = 19'h55;
        length = 19'd3;
      end
      out_ready = (mode == 1) ? ((c % 4 == 1) || (c % 4 == 0)) : 1'b1;
      #1;
      if (c == 1) begin
        chk("busy1", 32'(busy), 32'd1);
        chk("rd1", 32'(mem_rd), 32'(len != 0));
      end
      if (c == 2)
        chk("valid2", 32'(out_valid), 32'(len != 0));
      if (stall) begin
        chk("stall_v", 32'(out_valid), 32'd1);
        chk("stall_d", 32'(out_data), 32'(pdata));
      end
      if (mem_rd) begin
        ea = base + issued;
        chk("addr", 32'(mem_addr), 32'(ea));
        issued = issued + 1'b1;
      end
      if (out_valid && out_ready) begin
        ea = base + 19'(beats);
        ed = ea[7:0];
        chk("data", 32'(out_data), 32'(ed));
        sum = sum + 16'(out_data);
        beats++;
      end
      chk("outst", 32'((32'(issued) - 32'(beats)) <= 2), 32'd1);
      stall = out_valid && !out_ready;
      pdata = out_data;
      if (done) begin
        fin = 1'b1;
        if (mode != 1)
          chk("done_cyc", 32'(c), (len == 0) ? 32'd1 : 32'(len) + 32'd2);
        chk("beats", 32'(beats), 32'(len));
        chk("issued", 32'(issued), 32'(len));
`ifdef RD_CHECKSUM_EN
        chk("csum", 32'(checksum), 32'(sum));
`endif
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_rd", 32'(mem_rd), 32'd0);
`ifdef RD_CHECKSUM_EN
      chk("csum_hold", 32'(checksum), 32'(sum));
`endif
    end
  endtask

  initial begin
    #1;
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
`ifdef RD_CHECKSUM_EN
    chk("rst_csum", 32'(checksum), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_burst(19'h10, 19'd4, 0);
`ifdef RD_CHECKSUM_EN
    chk("csum_46", 32'(checksum), 32'h46);
`endif
    run_burst(19'h0, 19'd0, 0);
    run_burst(19'h20, 19'd8, 1);
    run_burst(19'h7FFFE, 19'd4, 0);
    run_burst(19'h30, 19'd5, 2);

    // abort a length-10 burst after its 3rd beat
    @(negedge clk);
    start = 1'b1;
    base_addr = 19'h40;
    length = 19'd10;
    out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre_abort_d", 32'(out_data), 32'h42);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_rd", 32'(mem_rd), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_done", 32'(done), 32'd0);
    run_burst(19'h0, 19'd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_mem_reader.md
LAYER_MEM_READER -- requirements
Module: layer_mem_reader

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE, default 19, meaning the width of the memory address, length and internal counters.
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning the width of one memory word and one stream beat.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1, a one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 The module SHALL have port base_addr, input, ADDR_SIZE, the first word address, captured with start.
REQ-007 The module SHALL have port length, input, ADDR_SIZE, the number of words to read, captured with start.
REQ-008 The module SHALL have port mem_addr, output, ADDR_SIZE, the read address to the synchronous memory (1-cycle read latency).
REQ-009 The module SHALL have port mem_rd, output, 1, which qualifies mem_addr as a read issued this cycle.
REQ-010 The module SHALL have port mem_data, input, DATA_W, memory read data, valid the cycle after the mem_rd cycle.
REQ-011 The module SHALL have port out_data, output, DATA_W, the stream data to the layer.
REQ-012 The module SHALL have port out_valid, output, 1, stream valid.
REQ-013 The module SHALL have port out_ready, input, 1, stream ready; a beat transfers when out_valid and out_ready are both 1.
REQ-014 The module SHALL have port busy, output, 1, which is high from start acceptance until done.
REQ-015 The module SHALL have port done, output, 1, a one-cycle pulse at burst completion.
REQ-016 The module SHALL have port checksum, output, 16, a running byte sum; this port is present only with RD_CHECKSUM_EN.

Function
REQ-017 The module SHALL implement states IDLE, FETCH and DONE: IDLE goes to FETCH on start with length>0, or to DONE on start with length==0; FETCH goes to DONE in the cycle after the last beat transfers; DONE returns to IDLE after one cycle.
REQ-018 done SHALL be 1 only in DONE; busy SHALL be 1 in FETCH and DONE.
REQ-019 A read SHALL be issued (mem_rd=1) only in FETCH, while issued<length and (buffer occupancy + reads in flight - pop this cycle) < 2.
REQ-020 The module SHALL hold an internal 2-entry FIFO that absorbs returned data; no returned word is ever dropped or duplicated.
REQ-021 The k-th read SHALL use mem_addr = base_addr + k, modulo 2^ADDR_SIZE, so addresses wrap silently.
REQ-022 The first mem_rd SHALL occur in the cycle after start is accepted, and the first out_valid two cycles after acceptance.
REQ-023 With out_ready held at 1, the module SHALL sustain 1 beat per cycle; a length-N burst then completes with done exactly N+2 cycles after acceptance.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-025 Beats SHALL be emitted in address order; out_data is the FIFO head.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 When out_valid=0, mem_addr SHALL hold its last value and out_data SHALL be don't-care.

Reset
REQ-028 On reset_n=0, asynchronously: the state SHALL go to IDLE, the FIFO and counters SHALL be cleared, and in-flight reads SHALL be discarded.
REQ-029 Reset values: mem_rd=0, out_valid=0, busy=0, done=0, mem_addr=0, out_data=0, checksum=0.
REQ-030 A reset during FETCH SHALL abort the burst with no done pulse, and no stale beat SHALL appear after release.

Configuration
REQ-031 With macro RD_CHECKSUM_EN defined, checksum SHALL clear on start acceptance, add each transferred beat (zero-extended, mod 2^16), and remain stable from done until the next start.
REQ-032 Without RD_CHECKSUM_EN, the checksum port and adder SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Test: base=0x10, length=4, memory[i]=i, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles; done 6 cycles after start; with RD_CHECKSUM_EN, checksum=0x46.
REQ-034 Test: length=0 -> done pulses the cycle after start; mem_rd is never asserted; out_valid stays 0.
REQ-035 Test: length=8, out_ready toggling 1,0,0,1 -> all 8 bytes in order; out_data stable while stalled; mem_rd never over-issues (at most 2 outstanding).
REQ-036 Test: base=0x7FFFE, length=4, ADDR_SIZE=19 -> mem_addr sequence is 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-037 Test: reset_n low for 1 cycle after the 3rd beat of length=10, then start base=0 length=2 -> only the 2 new beats appear, one done pulse, no leftover data.
REQ-038 Test: start reasserted mid-burst -> ignored; the original burst completes unchanged.
